// File: rtl/lane_scheduler_pkg.sv
// Shared game constants: game_state encodings, the level-to-period table and lane counter width.
package lane_scheduler_pkg;

  localparam int LANE_CNT_W = 5;
  localparam int LEVEL_W    = 4;
  localparam int GS_W       = 2;

  localparam logic [GS_W-1:0] GS_IDLE  = 2'b00;
  localparam logic [GS_W-1:0] GS_RUN   = 2'b01;
  localparam logic [GS_W-1:0] GS_PAUSE = 2'b10;
  localparam logic [GS_W-1:0] GS_OVER  = 2'b11;

  localparam logic [LANE_CNT_W-1:0] L1_PERIOD = 5'd16;
  localparam logic [LANE_CNT_W-1:0] L2_PERIOD = 5'd14;
  localparam logic [LANE_CNT_W-1:0] L3_PERIOD = 5'd12;
  localparam logic [LANE_CNT_W-1:0] L4_PERIOD = 5'd10;
  localparam logic [LANE_CNT_W-1:0] L5_PERIOD = 5'd9;
  localparam logic [LANE_CNT_W-1:0] L6_PERIOD = 5'd8;
  localparam logic [LANE_CNT_W-1:0] L7_PERIOD = 5'd6;
  localparam logic [LANE_CNT_W-1:0] L8_PERIOD = 5'd6;
  localparam logic [LANE_CNT_W-1:0] L9_PERIOD = 5'd3;

  localparam logic [LEVEL_W-1:0] LEVEL_DEFAULT = 4'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_e;

  // Out-of-range levels fall back to level 1
  function automatic logic [LEVEL_W-1:0] level_map(input logic [LEVEL_W-1:0] lvl);
    logic [LEVEL_W-1:0] w_lvl;
    if ((lvl >= 4'd1) && (lvl <= 4'd9)) begin
      w_lvl = lvl;
    end else begin
      w_lvl = LEVEL_DEFAULT;
    end
    return w_lvl;
  endfunction

  function automatic logic [LANE_CNT_W-1:0] level_period(input logic [LEVEL_W-1:0] lvl);
    logic [LANE_CNT_W-1:0] w_per;
    case (lvl)
      4'd1:    w_per = L1_PERIOD;
      4'd2:    w_per = L2_PERIOD;
      4'd3:    w_per = L3_PERIOD;
      4'd4:    w_per = L4_PERIOD;
      4'd5:    w_per = L5_PERIOD;
      4'd6:    w_per = L6_PERIOD;
      4'd7:    w_per = L7_PERIOD;
      4'd8:    w_per = L8_PERIOD;
      4'd9:    w_per = L9_PERIOD;
      default: w_per = L1_PERIOD;
    endcase
    return w_per;
  endfunction

endpackage

// File: rtl/lane_scheduler_if.sv
// Control inputs from the game FSM and strobe outputs towards the car instances.
interface lane_scheduler_if #(
  parameter int N_LANES = 4
);
  import lane_scheduler_pkg::*;

  logic [GS_W-1:0]    i_game_state;
  logic [LEVEL_W-1:0] i_level;
  logic               i_Restart;
  logic [N_LANES-1:0] o_step;
  logic               o_respawn;
  logic               o_running;
  logic [LEVEL_W-1:0] o_level_applied;

  modport master (
    output i_game_state, i_level, i_Restart,
    input  o_step, o_respawn, o_running, o_level_applied
  );

  modport slave (
    input  i_game_state, i_level, i_Restart,
    output o_step, o_respawn, o_running, o_level_applied
  );

endinterface

// File: rtl/lane_timer.sv
// One lane's movement counter: counts base ticks and emits a registered strobe when its period expires.
module lane_timer
  import lane_scheduler_pkg::*;
(
  input  logic                  i_Clk,
  input  logic                  i_Reset_n,
  input  logic                  i_clear,
  input  logic                  i_hold,
  input  logic                  i_tick,
  input  logic [LANE_CNT_W-1:0] i_period,
  output logic                  o_step
);

  logic [LANE_CNT_W-1:0] r_cnt;
  logic                  r_step;
  logic                  w_expire;

  // >= rather than == so a period that shrank below the count still expires
  always_comb begin
    w_expire = (r_cnt >= (i_period - LANE_CNT_W'(1)));
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_cnt  <= {LANE_CNT_W{1'b0}};
      r_step <= 1'b0;
    end else if (i_clear) begin
      r_cnt  <= {LANE_CNT_W{1'b0}};
      r_step <= 1'b0;
    end else if (i_hold || !i_tick) begin
      r_step <= 1'b0;
    end else if (w_expire) begin
      r_cnt  <= {LANE_CNT_W{1'b0}};
      r_step <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + LANE_CNT_W'(1);
      r_step <= 1'b0;
    end
  end

  assign o_step = r_step;

endmodule

// File: rtl/lane_scheduler.sv
// Central lane speed scheduler: one shared prescaler, game-state FSM, level latch and per-lane step strobes.
module lane_scheduler
  import lane_scheduler_pkg::*;
#(
  parameter int N_LANES  = 4,
  parameter int BASE_DIV = 5000
) (
  input logic             i_Clk,
  input logic             i_Reset_n,
  lane_scheduler_if.slave bus
);

  localparam int                 PRESC_W   = $clog2(BASE_DIV);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(BASE_DIV - 1);

  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  state_e             r_state;
  state_e             w_state_nxt;
  logic [PRESC_W-1:0] r_presc;
  logic [LEVEL_W-1:0] r_level_applied;
  logic [LEVEL_W-1:0] w_level_now;
  logic               r_restart_d;
  logic               r_respawn;
  logic               r_running;
  logic               w_run_go;
  logic               w_enter_run;
  logic               w_clear;
  logic               w_base_tick;
  logic [N_LANES-1:0] w_step;

  // Reset asserts immediately but releases only after two clock edges
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  always_ff @(posedge i_Clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A tick in the cycle the game state changes is dropped; resuming from pause keeps counts
  always_comb begin
    w_state_nxt = S_IDLE;
    if (bus.i_Restart) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (bus.i_game_state)
        GS_IDLE:  w_state_nxt = S_IDLE;
        GS_RUN:   w_state_nxt = S_RUN;
        GS_PAUSE: w_state_nxt = S_PAUSE;
        GS_OVER:  w_state_nxt = S_OVER;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
    w_run_go    = (r_state == S_RUN) && (w_state_nxt == S_RUN);
    w_enter_run = (r_state != S_RUN) && (w_state_nxt == S_RUN);
    w_clear     = bus.i_Restart || (w_enter_run && (r_state != S_PAUSE));
    w_base_tick = w_run_go && (r_presc == PRESC_MAX);
    w_level_now = level_map(bus.i_level);
  end

  always_ff @(posedge i_Clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_presc         <= {PRESC_W{1'b0}};
      r_level_applied <= LEVEL_DEFAULT;
      r_restart_d     <= 1'b0;
      r_respawn       <= 1'b0;
      r_running       <= 1'b0;
    end else begin
      r_restart_d <= bus.i_Restart;
      r_respawn   <= bus.i_Restart && !r_restart_d;
      r_running   <= (w_state_nxt == S_RUN);
      if (w_clear) begin
        r_presc <= {PRESC_W{1'b0}};
      end else if (w_run_go) begin
        r_presc <= (r_presc == PRESC_MAX) ? {PRESC_W{1'b0}} : (r_presc + PRESC_W'(1));
      end else begin
        r_presc <= r_presc;
      end
      if (w_base_tick || w_enter_run) begin
        r_level_applied <= w_level_now;
      end else begin
        r_level_applied <= r_level_applied;
      end
    end
  end

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    logic [LANE_CNT_W-1:0] w_period;
    assign w_period = level_period(w_level_now) + LANE_CNT_W'(k);

    lane_timer u_lane_timer (
      .i_Clk     (i_Clk),
      .i_Reset_n (w_rst_n),
      .i_clear   (w_clear),
      .i_hold    (!w_run_go),
      .i_tick    (w_base_tick),
      .i_period  (w_period),
      .o_step    (w_step[k])
    );
  end

  assign bus.o_step          = w_step;
  assign bus.o_respawn       = r_respawn;
  assign bus.o_running       = r_running;
  assign bus.o_level_applied = r_level_applied;

endmodule

// File: tb/tb_lane_scheduler.sv
// Randomized bench for lane_scheduler: an arithmetic reference model fills scoreboard queues, a monitor drains them.
module tb_lane_scheduler;

  localparam int N_LANES  = 4;
  localparam int BASE_DIV = 4;
  localparam int GS_IDLE  = 0;
  localparam int GS_RUN   = 1;
  localparam int GS_PAUSE = 2;
  localparam int GS_OVER  = 3;

  typedef struct { int c; logic [N_LANES-1:0] step; logic respawn; } ev_t;
  typedef struct { int c; logic running; logic [3:0] level; } st_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;
  ev_t  ev_q[$];
  st_t  st_q[$];

  int m_state, m_hold, m_run_time, m_ticks, m_level;
  int m_last[N_LANES];
  bit m_in_reset, m_prev_rst;
  int cur_gs, cur_lvl;

  lane_scheduler_if #(.N_LANES(N_LANES)) sif ();

  lane_scheduler #(.N_LANES(N_LANES), .BASE_DIV(BASE_DIV)) dut (
    .i_Clk     (clk),
    .i_Reset_n (rst_n),
    .bus       (sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lvl_map(input int l);
    return (l >= 1 && l <= 9) ? l : 1;
  endfunction

  function automatic int lvl_per(input int l);
    case (lvl_map(l))
      2: return 14;
      3: return 12;
      4: return 10;
      5: return 9;
      6: return 8;
      7: return 6;
      8: return 6;
      9: return 3;
      default: return 16;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  task automatic model_clear();
    m_run_time = 0;
    m_ticks    = 0;
    for (int k = 0; k < N_LANES; k++) m_last[k] = 0;
  endtask

  // Lane k strobes on the n-th base tick since clear when n - last_strobe_tick >= period_k
  task automatic model_cycle(input int gs, input int lvl, input bit rst);
    ev_t e;
    st_t s;
    int  nxt;
    bit  run_go, tick;
    e.c = cyc + 1; e.step = '0; e.respawn = 1'b0;
    s.c = cyc + 1; s.running = 1'b0; s.level = 4'd1;
    if (m_in_reset || m_hold > 0) begin
      if (m_hold > 0) m_hold--;
      m_state = GS_IDLE; m_prev_rst = 1'b0; m_level = 1;
      model_clear();
    end else begin
      nxt    = rst ? GS_IDLE : gs;
      run_go = (m_state == GS_RUN) && (nxt == GS_RUN);
      tick   = run_go && ((m_run_time % BASE_DIV) == BASE_DIV - 1);
      if (tick) begin
        m_ticks++;
        m_level = lvl_map(lvl);
        for (int k = 0; k < N_LANES; k++) begin
          if (m_ticks - m_last[k] >= lvl_per(lvl) + k) begin
            e.step[k] = 1'b1;
            m_last[k] = m_ticks;
          end
        end
      end
      if (run_go) m_run_time++;
      if (m_state != GS_RUN && nxt == GS_RUN) begin
        m_level = lvl_map(lvl);
        if (m_state != GS_PAUSE) model_clear();
      end
      if (rst) model_clear();
      e.respawn  = rst && !m_prev_rst;
      m_prev_rst = rst;
      s.running  = (nxt == GS_RUN);
      s.level    = 4'(m_level);
      m_state    = nxt;
    end
    st_q.push_back(s);
    if (e.step != '0 || e.respawn) ev_q.push_back(e);
  endtask

  task automatic drive(input int gs, input int lvl, input bit rst, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      sif.i_game_state = 2'(gs);
      sif.i_level      = 4'(lvl);
      sif.i_Restart    = rst;
      cur_gs = gs; cur_lvl = lvl;
      model_cycle(gs, lvl, rst);
    end
  endtask

  task automatic release_reset();
    @(posedge clk); #2;
    rst_n      = 1'b1;
    m_in_reset = 1'b0;
    m_hold     = 2;
    model_cycle(cur_gs, cur_lvl, 1'b0);
  endtask

  task automatic async_reset(input int hold_cycles);
    st_t s;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_step", 32'(sif.o_step), 32'd0);
    check("arst_respawn", 32'(sif.o_respawn), 32'd0);
    check("arst_running", 32'(sif.o_running), 32'd0);
    check("arst_level", 32'(sif.o_level_applied), 32'd1);
    st_q.delete();
    ev_q.delete();
    m_in_reset = 1'b1;
    s.c = cyc; s.running = 1'b0; s.level = 4'd1;
    st_q.push_back(s);
    model_cycle(cur_gs, cur_lvl, 1'b0);
    drive(cur_gs, cur_lvl, 1'b0, hold_cycles);
    release_reset();
  endtask

  initial begin : monitor
    ev_t e;
    st_t s;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (st_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL status_queue cycle=%0d got=empty want=record", cyc);
        end else begin
          s = st_q.pop_front();
          check("status_tag", 32'(s.c), 32'(cyc));
          check("running", 32'(sif.o_running), 32'(s.running));
          check("level_applied", 32'(sif.o_level_applied), 32'(s.level));
        end
        while (ev_q.size() > 0 && ev_q[0].c < cyc) begin
          e = ev_q.pop_front();
          checks++; errors++;
          $display("FAIL missed_event cycle=%0d got=none want=step %0h respawn %0d at cycle %0d",
                   cyc, e.step, e.respawn, e.c);
        end
        if (sif.o_step != '0 || sif.o_respawn) begin
          if (ev_q.size() > 0 && ev_q[0].c == cyc) begin
            e = ev_q.pop_front();
            check("step", 32'(sif.o_step), 32'(e.step));
            check("respawn", 32'(sif.o_respawn), 32'(e.respawn));
          end else begin
            check("unexpected_event", {27'd0, sif.o_respawn, sif.o_step}, 32'd0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    int guard;
    st_t s0;
    sif.i_game_state = 2'(GS_RUN);
    sif.i_level      = 4'd1;
    sif.i_Restart    = 1'b0;
    cur_gs = GS_RUN; cur_lvl = 1;
    m_in_reset = 1'b1; m_hold = 0; m_state = GS_IDLE; m_prev_rst = 1'b0; m_level = 1;
    model_clear();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    s0.c = cyc; s0.running = 1'b0; s0.level = 4'd1;
    st_q.push_back(s0);
    model_cycle(cur_gs, cur_lvl, 1'b0);
    chk_en = 1'b1;
    drive(GS_RUN, 1, 1'b0, 2);
    release_reset();

    // Basic run, then pause mid-interval and resume
    drive(GS_RUN, 1, 1'b0, 400);
    drive(GS_PAUSE, 1, 1'b0, 100);
    drive(GS_RUN, 1, 1'b0, 250);

    // Level 1 -> 9 while lane 0 holds a count of 10
    guard = 0;
    while ((m_ticks - m_last[0]) != 10 && guard < 200) begin
      drive(GS_RUN, 1, 1'b0, 1);
      guard++;
    end
    check("align_cnt0", 32'(guard < 200), 32'd1);
    drive(GS_RUN, 9, 1'b0, 120);
    drive(GS_RUN, 0, 1'b0, 200);
    drive(GS_RUN, 12, 1'b0, 200);
    drive(GS_RUN, 1, 1'b0, 37);

    // Restart held for three cycles, starting on a base-tick cycle
    guard = 0;
    while (!(m_state == GS_RUN && (m_run_time % BASE_DIV) == BASE_DIV - 1) && guard < 20) begin
      drive(GS_RUN, 1, 1'b0, 1);
      guard++;
    end
    check("align_tick", 32'(guard < 20), 32'd1);
    drive(GS_RUN, 1, 1'b1, 3);
    drive(GS_RUN, 1, 1'b0, 200);

    for (int sg = 0; sg < 30; sg++) begin
      int r, gs, lvl, len;
      r   = $urandom_range(0, 9);
      gs  = (r < 6) ? GS_RUN : ((r < 8) ? GS_PAUSE : ((r == 8) ? GS_OVER : GS_IDLE));
      lvl = $urandom_range(0, 15);
      len = $urandom_range(1, 150);
      if ($urandom_range(0, 4) == 0) drive(gs, lvl, 1'b1, $urandom_range(1, 3));
      drive(gs, lvl, 1'b0, len);
    end

    // Asynchronous reset in the middle of a run
    drive(GS_RUN, 3, 1'b0, 150);
    async_reset(5);
    drive(GS_RUN, 1, 1'b0, 200);
    drive(GS_IDLE, 1, 1'b0, 5);

    @(negedge clk); #1;
    chk_en = 1'b0;
    while (ev_q.size() > 0 && ev_q[0].c <= cyc) begin
      ev_t e;
      e = ev_q.pop_front();
      checks++; errors++;
      $display("FAIL missed_event cycle=%0d got=none want=step %0h at cycle %0d", cyc, e.step, e.c);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
